div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: 32-bit signed restoring divider sequencer.
// The divider works on operand magnitudes and fixes up the signs at the end.
// It produces the quotient (LO) and the remainder (HI) with fixed 35-edge latency.
// Division truncates toward zero, so the remainder takes the dividend's sign.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hi_w,
    output logic        lo_w,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_FIN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        if (v[31]) begin
            abs32 = 32'd0 - v;
        end else begin
            abs32 = v;
        end
    endfunction

    // Conditional two's-complement negation used for the final sign fix-up.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        if (n) begin
            neg_if = 32'd0 - v;
        end else begin
            neg_if = v;
        end
    endfunction

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [31:0] dvd_r;      // dividend magnitude captured at start
    logic [31:0] dvs_r;      // divisor magnitude captured at start
    logic        sgn_dvd_r;  // remainder must be negated
    logic        sgn_quo_r;  // quotient must be negated
    logic [31:0] rem_r;      // partial remainder
    logic [31:0] quo_r;      // dividend bits shift out of the top; quotient bits shift in at the bottom
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        hi_w_r;
    logic        lo_w_r;
    logic        busy_r;
    logic        done_r;
    logic        div_zero_r;

    logic [32:0] rem_shift_s;
    logic        ge_s;
    logic [31:0] rem_sub_s;
    logic [31:0] rem_next_s;

    // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
    // When the subtraction is kept, the true difference is below 2^31.
    // So a 32-bit wrap-around subtract gives the exact result.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[31]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
        rem_sub_s   = rem_shift_s[31:0] - dvs_r;
        if (ge_s) begin
            rem_next_s = rem_sub_s;
        end else begin
            rem_next_s = rem_shift_s[31:0];
        end
    end

    // Control FSM, datapath registers and registered output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            dvd_r      <= 32'd0;
            dvs_r      <= 32'd0;
            sgn_dvd_r  <= 1'b0;
            sgn_quo_r  <= 1'b0;
            rem_r      <= 32'd0;
            quo_r      <= 32'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            hi_w_r     <= 1'b0;
            lo_w_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (flush) begin
            // Cancel: back to idle without any strobe; results already written stay put.
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            hi_w_r     <= 1'b0;
            lo_w_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            hi_w_r     <= 1'b0;
            lo_w_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dvd_r     <= abs32(dividend);
                        dvs_r     <= abs32(divisor);
                        sgn_dvd_r <= dividend[31];
                        sgn_quo_r <= dividend[31] ^ divisor[31];
                        busy_r    <= 1'b1;
                        state_r   <= ST_CHECK;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (dvs_r == 32'd0) begin
                        done_r     <= 1'b1;
                        div_zero_r <= 1'b1;
                        state_r    <= ST_ERR;
                    end else begin
                        cnt_r   <= 5'd0;
                        rem_r   <= 32'd0;
                        quo_r   <= dvd_r;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[30:0], ge_s};
                    if (cnt_r == 5'd31) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                        state_r <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    hi_r    <= neg_if(rem_r, sgn_dvd_r);
                    lo_r    <= neg_if(quo_r, sgn_quo_r);
                    done_r  <= 1'b1;
                    hi_w_r  <= 1'b1;
                    lo_w_r  <= 1'b1;
                    state_r <= ST_FIN;
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi_out   = hi_r;
    assign lo_out   = lo_r;
    assign hi_w     = hi_w_r;
    assign lo_w     = lo_w_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a plain-arithmetic reference model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_w;
    logic        lo_w;
    logic        busy;
    logic        done;
    logic        div_zero;

    div_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .dividend (dividend),
        .divisor  (divisor),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .hi_w     (hi_w),
        .lo_w     (lo_w),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed truncating division; div-by-zero keeps the old HI/LO values.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input int e0);
        exp_t e;
        e.err = (b == 32'd0);
        if (e.err) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.cyc = e0 + 1;
        end else begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'd0;
            end else begin
                e.lo = $signed(a) / $signed(b);
                e.hi = $signed(a) % $signed(b);
            end
            e.cyc = e0 + 34;
            m_hi  = e.hi;
            m_lo  = e.lo;
        end
        sb.push_back(e);
    endtask

    // Completes a request whose inputs are already driven: E0 edge, then expectation.
    task automatic commit(input logic [31:0] a, input logic [31:0] b, input bit cancel);
        int e0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        e0       = cyc;
        dividend = $urandom;
        divisor  = $urandom;
        if (!cancel) begin
            model(a, b, e0);
        end
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit cancel);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        commit(a, b, cancel);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    // Waits for the done cycle, then offers a new start there; it must be ignored.
    task automatic start_in_done_cycle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
    endtask

    // Monitor: any strobe pops one expectation and compares the whole response.
    always @(negedge clk) begin
        if (reset === 1'b1 && (done || hi_w || lo_w || div_zero)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {28'd0, done, hi_w, lo_w, div_zero}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done", 32'(done), 32'd1);
                chk("div_zero", 32'(div_zero), 32'(e.err));
                chk("hi_w", 32'(hi_w), 32'(!e.err));
                chk("lo_w", 32'(lo_w), 32'(!e.err));
                chk("hi_out", hi_out, e.hi);
                chk("lo_out", lo_out, e.lo);
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        reset    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        chk("rst_outputs", {hi_out | lo_out}, 32'd0);
        chk("rst_strobes", {27'd0, busy, done, hi_w, lo_w, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        issue(32'd7, 32'd2, 1'b0);              wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);      wait_idle();
        issue(32'd7, 32'hFFFF_FFFE, 1'b0);      wait_idle();
        issue(32'd5, 32'd0, 1'b0);              wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
        issue(32'd0, 32'd3, 1'b0);              wait_idle();

        // Start offered during the FIN and ERR cycles
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);      start_in_done_cycle();
        issue(32'd11, 32'd0, 1'b0);             start_in_done_cycle();

        // Reset mid-operation at E10, then 7/2 accepted on the first edge after release
        issue(32'd7, 32'd2, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs", {hi_out | lo_out}, 32'd0);
        chk("async_rst_strobes", {27'd0, busy, done, hi_w, lo_w, div_zero}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        commit(32'd7, 32'd2, 1'b0);
        wait_idle();

        // Second start at E5 ignored, flush at E20 cancels with no pulses
        issue(32'd100, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        dividend = 32'd3;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_restart", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_after_flush", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        chk("flush_no_pulse_sb", 32'(sb.size()), 32'd0);

        // Flush beats start in IDLE
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        dividend = 32'd8;
        divisor  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_over_start", 32'(busy), 32'd0);

        // Randomized operands; operands scrambled after E0 inside commit()
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                2:       a = 32'd0 - 32'($urandom_range(1, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            issue(a, b, 1'b0);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
